// File: rtl/task_sched_pkg.sv
// Shared types and defaults for the task scheduler: FSM state encoding,
// task-line geometry and the default watchdog limit.
package task_sched_pkg;

  localparam int unsigned N_TASKS_DEF = 16;
  localparam int unsigned ID_W_DEF    = 4;
  localparam logic [15:0] TIMEOUT_DEF = 16'd4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/task_sched_rr_pick.sv
// Combinational round-robin picker: first set bit of elig scanning upward
// from rr_ptr with wrap-around.
module rr_pick
  import task_sched_pkg::*;
#(
  parameter int unsigned N_TASKS = N_TASKS_DEF,
  parameter int unsigned ID_W    = ID_W_DEF
) (
  input  logic [N_TASKS-1:0] elig,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    sel
);

  logic [2*N_TASKS-1:0] dbl;
  logic [N_TASKS-1:0]   rot;
  logic [ID_W-1:0]      off;
  logic [ID_W:0]        sum;

  // Rotating the doubled vector puts rr_ptr at bit 0, so a plain
  // lowest-bit priority encode gives the offset from the pointer.
  assign dbl = {elig, elig};
  assign rot = dbl[rr_ptr +: N_TASKS];

  always_comb begin
    off = '0;
    for (int unsigned i = 0; i < N_TASKS; i++) begin
      if (rot[N_TASKS-1-i]) off = ID_W'(N_TASKS-1-i);
    end
  end

  assign found = |elig;
  assign sum   = {1'b0, off} + {1'b0, rr_ptr};
  assign sel   = (sum >= (ID_W+1)'(N_TASKS)) ? ID_W'(sum - (ID_W+1)'(N_TASKS))
                                             : sum[ID_W-1:0];

endmodule

// File: rtl/task_sched.sv
// Round-robin scheduler feeding one shared task engine, with per-task enable,
// watchdog abort and sticky timeout status.
module task_sched
  import task_sched_pkg::*;
#(
  parameter int unsigned      N_TASKS   = N_TASKS_DEF,
  parameter int unsigned      ID_W      = ID_W_DEF,
  parameter int unsigned      CNT_W     = 16,
  parameter logic [CNT_W-1:0] P_TIMEOUT = CNT_W'(TIMEOUT_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_TASKS-1:0] en_mask,
  input  logic [N_TASKS-1:0] req,
  output logic [N_TASKS-1:0] ack,
  output logic               start,
  output logic [ID_W-1:0]    task_id,
  input  logic               done,
  output logic               abort,
  output logic               busy,
  output logic               timeout_err,
  output logic [ID_W-1:0]    err_id,
  input  logic               err_clr
);

  localparam logic [CNT_W-1:0] WD_LAST = P_TIMEOUT - CNT_W'(1);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_TASKS-1);

  state_t             state, state_d;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_d, task_id_d, err_id_d, sel, next_id;
  logic [CNT_W-1:0]   wdog, wdog_d;
  logic               start_d, abort_d, terr_d, found, expire;
  logic [N_TASKS-1:0] elig;

  assign elig = req & en_mask;

  rr_pick #(
    .N_TASKS (N_TASKS),
    .ID_W    (ID_W)
  ) u_pick (
    .elig   (elig),
    .rr_ptr (rr_ptr),
    .found  (found),
    .sel    (sel)
  );

  assign busy    = (state == RUN);
  assign next_id = (task_id == LAST_ID) ? '0 : task_id + ID_W'(1);
  // done in the same cycle as expiry suppresses the timeout entirely
  assign expire  = busy && (P_TIMEOUT != '0) && (wdog == WD_LAST) && !done;

  always_comb begin
    ack = '0;
    if (busy) ack[task_id] = 1'b1;
  end

  always_comb begin
    state_d   = state;
    rr_ptr_d  = rr_ptr;
    wdog_d    = wdog;
    task_id_d = task_id;
    err_id_d  = err_id;
    start_d   = 1'b0;
    abort_d   = 1'b0;
    terr_d    = expire | (timeout_err & ~err_clr);
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d   = RUN;
          task_id_d = sel;
          start_d   = 1'b1;
          wdog_d    = '0;
        end
      end
      RUN: begin
        if (wdog != '1) wdog_d = wdog + CNT_W'(1);
        if (done || expire) begin
          state_d  = HOLD;
          rr_ptr_d = next_id;
        end
        if (expire) begin
          abort_d  = 1'b1;
          err_id_d = task_id;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      wdog        <= '0;
      task_id     <= '0;
      err_id      <= '0;
      start       <= 1'b0;
      abort       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      wdog        <= wdog_d;
      task_id     <= task_id_d;
      err_id      <= err_id_d;
      start       <= start_d;
      abort       <= abort_d;
      timeout_err <= terr_d;
    end
  end

endmodule

// File: tb/tb_task_sched.sv
// Scoreboard bench for task_sched: stimulus pushes expected grants, completions,
// aborts and error status; an independent monitor pops and compares.
module tb_task_sched;

  localparam int P = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] en_mask, req, ack;
  logic        start, done, abort, busy, timeout_err, err_clr;
  logic [3:0]  task_id, err_id;

  task_sched #(
    .N_TASKS   (16),
    .ID_W      (4),
    .CNT_W     (16),
    .P_TIMEOUT (16'd8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_mask     (en_mask),
    .req         (req),
    .ack         (ack),
    .start       (start),
    .task_id     (task_id),
    .done        (done),
    .abort       (abort),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_id      (err_id),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int id; } ev_t;
  ev_t grant_q[$], end_q[$], abort_q[$], terr_q[$];

  int checks = 0, failures = 0;
  bit mon_en = 0, noise = 0, terr_m = 0, prev_busy = 0;
  int rr_ptr_m = 0;
  ev_t me;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Reference arbitration: scan upward from the pointer, wrapping at 16.
  function automatic int pick(logic [15:0] elig, int ptr);
    for (int k = 0; k < 16; k++)
      if (elig[(ptr + k) % 16]) return (ptr + k) % 16;
    return -1;
  endfunction

  task automatic push_terr(input bit expiry);
    bit nxt;
    nxt = expiry ? 1'b1 : (err_clr ? 1'b0 : terr_m);
    terr_m = nxt;
    terr_q.push_back('{cyc + 1, int'(nxt)});
  endtask

  task automatic idle_cycle(input bit clr);
    req = '0; done = 1'b0; err_clr = clr;
    push_terr(1'b0);
    @(negedge clk);
  endtask

  // Entered at the negedge of an IDLE cycle; returns at the next IDLE negedge.
  // d = RUN-cycle index where done is raised; d outside [0,P) means timeout.
  task automatic run_txn(input logic [15:0] r, input logic [15:0] m, input int d);
    logic [15:0] elig;
    int sel, len;
    bit tmo;
    req = r; en_mask = m;
    done    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    err_clr = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
    push_terr(1'b0);
    elig = r & m;
    if (elig == '0) begin
      @(negedge clk);
      return;
    end
    sel = pick(elig, rr_ptr_m);
    rr_ptr_m = (sel + 1) % 16;
    tmo = !(d >= 0 && d < P);
    len = tmo ? P : d + 1;
    grant_q.push_back('{cyc + 1, sel});
    end_q.push_back('{cyc + 1 + len, sel});
    if (tmo) abort_q.push_back('{cyc + 1 + len, sel});
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (noise) begin
        req = 16'($urandom); en_mask = 16'($urandom);
        err_clr = ($urandom_range(0, 3) == 0);
      end
      done = !tmo && (i == d);
      push_terr(tmo && (i == len - 1));
    end
    @(negedge clk);
    if (noise) begin
      req = 16'($urandom); done = 1'($urandom_range(0, 1));
      err_clr = ($urandom_range(0, 3) == 0);
    end else begin
      done = 1'b0;
    end
    push_terr(1'b0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("ack_onehot0", 32'($onehot0(ack)), 1);
      while (terr_q.size() > 0 && terr_q[0].cyc < cyc) void'(terr_q.pop_front());
      if (terr_q.size() > 0 && terr_q[0].cyc == cyc) begin
        me = terr_q.pop_front();
        check("timeout_err", 32'(timeout_err), me.id);
      end
      if (start) begin
        if (grant_q.size() == 0) check("unexpected_start", 32'(start), 0);
        else begin
          me = grant_q.pop_front();
          check("start_cycle", cyc, me.cyc);
          check("task_id", 32'(task_id), me.id);
          check("ack_grant", 32'(ack), 32'(1) << me.id);
          check("busy_at_start", 32'(busy), 1);
        end
      end
      if (prev_busy && !busy) begin
        if (end_q.size() == 0) check("unexpected_end", 32'(busy), 1);
        else begin
          me = end_q.pop_front();
          check("end_cycle", cyc, me.cyc);
          check("ack_after_end", 32'(ack), 0);
        end
      end
      if (abort) begin
        if (abort_q.size() == 0) check("unexpected_abort", 32'(abort), 0);
        else begin
          me = abort_q.pop_front();
          check("abort_cycle", cyc, me.cyc);
          check("err_id", 32'(err_id), me.id);
        end
      end
    end
    prev_busy = busy;
  end

  initial begin
    #500000;
    $display("FAIL time_limit: got cycle %0d expected completion", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; req = '0; en_mask = '0; done = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_start", 32'(start), 0);
    check("rst_task_id", 32'(task_id), 0);
    check("rst_abort", 32'(abort), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_err_id", 32'(err_id), 0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    run_txn(16'h0008, 16'hFFFF, 9);
    run_txn(16'h8000, 16'hFFFF, 1);
    repeat (4) run_txn(16'h8101, 16'hFFFF, 1);
    repeat (2) run_txn(16'h0003, 16'h0002, 2);
    run_txn(16'h0020, 16'hFFFF, -1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    run_txn(16'h0010, 16'hFFFF, P - 1);
    run_txn(16'h0001, 16'hFFFF, 0);

    noise = 1'b1;
    repeat (150) begin
      logic [15:0] r, m;
      r = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      m = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
      run_txn(r, m, $urandom_range(0, P + 2));
    end
    noise = 1'b0;
    req = '0; done = 1'b0; err_clr = 1'b0;
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    run_txn(16'h0040, 16'hFFFF, 0);
    mon_en = 1'b0;
    req = 16'h0400; en_mask = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    check("ack_before_reset", 32'(ack), 32'h0400);
    rst_n = 1'b0;
    #1;
    check("midrst_ack", 32'(ack), 0);
    check("midrst_start", 32'(start), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_abort", 32'(abort), 0);
    check("midrst_task_id", 32'(task_id), 0);
    @(negedge clk);
    req = '0; rst_n = 1'b1;
    grant_q.delete(); end_q.delete(); abort_q.delete(); terr_q.delete();
    rr_ptr_m = 0; terr_m = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    run_txn(16'h8001, 16'hFFFF, 1);
    run_txn(16'h0400, 16'hFFFF, 2);
    idle_cycle(1'b0);

    check("grant_q_drained", grant_q.size(), 0);
    check("end_q_drained", end_q.size(), 0);
    check("abort_q_drained", abort_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
